// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage: state encoding,
// datapath widths and the bubble value shared with the IF/ID flush logic.
package rv_pipe_pkg;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam int          INSN_W              = 32;
    localparam logic [31:0] PC_STEP             = 32'd4;
    localparam logic [31:0] BUBBLE_INSN_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response handshake between the fetch stage
// (master) and the instruction memory (slave).
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one instruction at a time over
// the imem handshake and presents it to IF/ID, honouring stall and redirect.
module fetch_unit
    import rv_pipe_pkg::*;
#(
    parameter logic [31:0]       RESET_PC    = 32'h0000_0000,
    parameter logic [INSN_W-1:0] BUBBLE_INSN = BUBBLE_INSN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hazard_detection,
    input  logic              NextPCSrc,
    input  logic [31:0]       branch_target,
    fetch_unit_if.master      imem,
    output logic [INSN_W-1:0] instruction_out,
    output logic [31:0]       pc_out,
    output logic [31:0]       sum_out,
    output logic              fetch_valid
);

    fetch_state_t      state, state_next;
    logic [31:0]       pc, pc_next;
    logic [INSN_W-1:0] hold_insn, hold_next;
    logic              drop, drop_next;
    logic [31:0]       target;
    logic [31:0]       pc_plus;

    assign target  = branch_target & ~32'd3;
    assign pc_plus = pc + PC_STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ISSUE;
            pc        <= RESET_PC;
            hold_insn <= '0;
            drop      <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            hold_insn <= hold_next;
            drop      <= drop_next;
        end
    end

    // drop marks an in-flight response that a redirect has made stale.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        hold_next  = hold_insn;
        drop_next  = drop;
        case (state)
            ISSUE: begin
                if (NextPCSrc) pc_next    = target;
                else           state_next = WAIT;
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    if (!drop && !NextPCSrc) begin
                        hold_next  = imem.imem_rdata;
                        state_next = HOLD;
                    end else begin
                        drop_next  = 1'b0;
                        state_next = ISSUE;
                        if (NextPCSrc) pc_next = target;
                    end
                end else if (NextPCSrc) begin
                    pc_next   = target;
                    drop_next = 1'b1;
                end
            end
            HOLD: begin
                if (NextPCSrc) begin
                    pc_next    = target;
                    state_next = ISSUE;
                end else if (!hazard_detection) begin
                    pc_next    = pc_plus;
                    state_next = ISSUE;
                end
            end
            default: state_next = ISSUE;
        endcase
    end

    always_comb begin
        imem.imem_addr  = pc;
        imem.imem_req   = (state == ISSUE) && !NextPCSrc && !rst;
        fetch_valid     = 1'b0;
        instruction_out = BUBBLE_INSN;
        pc_out          = '0;
        sum_out         = '0;
        if (state == HOLD) begin
            fetch_valid     = 1'b1;
            instruction_out = hold_insn;
            pc_out          = pc;
            sum_out         = pc_plus;
        end
    end

endmodule
